arith_seq: RTL and testbench



---
 rtl/arith_seq_pkg.sv | 13 +
 rtl/arith_slice.sv | 25 ++
 rtl/arith_seq.sv | 98 +++++++++
 tb/tb_arith_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/arith_seq_pkg.sv
// Shared types and constants for the byte-serial add/subtract sequencer.
package arith_seq_pkg;

  localparam int NBYTES_DEFAULT = 4;
  localparam int BYTE_W         = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/arith_slice.sv
// Combinational 8-bit add/subtract slice; reports the operand and sum sign bits
// actually seen by the adder so the caller can form signed overflow.
module arith_slice
  import arith_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              sub,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout,
  output logic              a_msb,
  output logic              b_msb,
  output logic              s_msb
);

  logic [BYTE_W-1:0] b_eff;

  assign b_eff        = sub ? ~b : b;
  assign {cout, sum}  = {1'b0, a} + {1'b0, b_eff} + {{BYTE_W{1'b0}}, cin};
  assign a_msb        = a[BYTE_W-1];
  assign b_msb        = b_eff[BYTE_W-1];
  assign s_msb        = sum[BYTE_W-1];

endmodule

// File: rtl/arith_seq.sv
// Wide add/subtract built from one 8-bit slice stepped LSB-first over NBYTES
// cycles, with the inter-byte carry held in a flop.
module arith_seq
  import arith_seq_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [BYTE_W*NBYTES-1:0] A,
  input  logic [BYTE_W*NBYTES-1:0] B,
  output logic                  busy,
  output logic                  done,
  output logic [BYTE_W*NBYTES-1:0] result,
  output logic                  cout,
  output logic                  ov
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_r, b_r;
  logic             sub_r;
  logic             load, last;

  logic [BYTE_W-1:0] s_sum;
  logic              s_cout, s_a_msb, s_b_msb, s_s_msb;

  assign load = start && (state == IDLE || state == DONE);
  assign last = (idx == LAST_IDX);
  assign busy = (state == RUN);
  assign done = (state == DONE);

  arith_slice u_slice (
    .a     (a_r[idx*BYTE_W +: BYTE_W]),
    .b     (b_r[idx*BYTE_W +: BYTE_W]),
    .sub   (sub_r),
    .cin   (carry),
    .sum   (s_sum),
    .cout  (s_cout),
    .a_msb (s_a_msb),
    .b_msb (s_b_msb),
    .s_msb (s_s_msb)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next state is defaulted first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: operand registers are deliberately left out of reset; they are only
  // read in RUN, which is always entered through a capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ov     <= 1'b0;
    end else if (load) begin
      a_r   <= A;
      b_r   <= B;
      sub_r <= sub;
      carry <= sub;
      idx   <= '0;
    end else if (state == RUN) begin
      result[idx*BYTE_W +: BYTE_W] <= s_sum;
      carry <= s_cout;
      if (last) begin
        cout <= s_cout;
        ov   <= (~s_a_msb & ~s_b_msb & s_s_msb) | (s_a_msb & s_b_msb & ~s_s_msb);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arith_seq.sv
// Directed bench for arith_seq: a reference model pushes expected results on
// start, and they are popped and compared when done pulses.
module tb_arith_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] A, B, result;
  logic         busy, done, cout, ov;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  arith_seq #(.NBYTES(NB)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ov     (ov)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t         m;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb    = s ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + (W+1)'(s);
    m.res = full[W-1:0];
    m.c   = full[W];
    m.v   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return m;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; start is sampled on the next rising edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    start = 1'b1;
    A     = a;
    B     = b;
    sub   = s;
    q.push_back(model(a, b, s));
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    sub   = 1'($urandom);
  endtask

  task automatic wait_done(input string tag, output int cyc, output int bcnt);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    cyc  = 0;
    bcnt = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_sb_entry"}, 64'(q.size() != 0), 64'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      if (seen) begin
        check({tag, "_result"}, 64'(result), 64'(e.res));
        check({tag, "_cout"},   64'(cout),   64'(e.c));
        check({tag, "_ov"},     64'(ov),     64'(e.v));
      end
    end
  endtask

  task automatic no_done_for(input string tag, input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done || busy) hits++;
    end
    check(tag, 64'(hits), 64'd0);
  endtask

  logic [W-1:0] va [6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000,
                           32'h8000_0000, 32'h0000_0005, 32'hDEAD_BEEF};
  logic [W-1:0] vb [6] = '{32'h0000_0001, 32'h8000_0000, 32'h0000_0001,
                           32'h0000_0001, 32'h0000_0005, 32'h1234_5678};
  logic         vs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int cyc, bc, c2, b2;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_done",   64'(done),   64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_cout",   64'(cout),   64'd0);
    check("rst_ov",     64'(ov),     64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Done is seen NBYTES+1 falling edges after the start edge; busy for NBYTES.
    start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_done("add_ff_1", cyc, bc);
    check("add_ff_1_latency", 64'(cyc), 64'(NB + 1));
    check("add_ff_1_busy",    64'(bc),  64'(NB));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start_op(va[i], vb[i], vs[i]);
      wait_done($sformatf("dir%0d", i), cyc, bc);
      check($sformatf("dir%0d_latency", i), 64'(cyc), 64'(NB + 1));
    end

    // A start pulse with fresh operands during RUN must be ignored.
    @(negedge clk);
    @(negedge clk);
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    @(negedge clk);
    start = 1'b1;
    A     = 32'hFFFF_FFFF;
    B     = 32'hFFFF_FFFF;
    sub   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start", cyc, bc);
    check("ignore_start_latency", 64'(cyc + 2), 64'(NB + 1));
    no_done_for("ignore_start_no_second_op", 8);
    check("ignore_start_sb_empty", 64'(q.size()), 64'd0);

    // Back-to-back: start held while in DONE launches the next op with no bubble.
    start_op(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    wait_done("b2b_first", cyc, bc);
    for (int i = 0; i < 4; i++) begin
      start_op($urandom, $urandom, 1'($urandom));
      wait_done($sformatf("b2b%0d", i), c2, b2);
      check($sformatf("b2b%0d_latency", i), 64'(c2), 64'(NB + 1));
      check($sformatf("b2b%0d_busy", i),    64'(b2), 64'(NB));
    end

    // Reset in the second RUN cycle aborts the op; no done may follow.
    @(negedge clk);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy",   64'(busy),   64'd0);
    check("abort_done",   64'(done),   64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_cout",   64'(cout),   64'd0);
    check("abort_ov",     64'(ov),     64'd0);
    void'(q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    no_done_for("abort_no_done", 10);

    @(negedge clk);
    start_op(32'h0000_0010, 32'h0000_0020, 1'b1);
    wait_done("after_abort", cyc, bc);
    check("after_abort_latency", 64'(cyc), 64'(NB + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
